// File: rtl/usb_stream_pkg.sv
// Shared types and helpers for the USB length-command streamer.
// Holds the FSM state encoding and the tail-word byte-lane mask.
package usb_stream_pkg;

  typedef enum logic {HDR, SEND} state_e;

  localparam int BYTES_PER_WORD = 4;

  function automatic logic [3:0] tkeep_for(input logic [31:0] remaining);
    logic [3:0] keep;
    if (remaining >= 32'(BYTES_PER_WORD)) begin
      keep = 4'hF;
    end else begin
      case (remaining[1:0])
        2'd1:    keep = 4'h1;
        2'd2:    keep = 4'h3;
        2'd3:    keep = 4'h7;
        default: keep = 4'h0;
      endcase
    end
    return keep;
  endfunction

endpackage

// File: rtl/usb_len_hdr_rx.sv
// Assembles a little-endian 32-bit length from four RX bytes; len_valid is combinational with the 4th byte.
// Accepts a byte whenever en is high; a partial header is dropped after TIMEOUT_CYC idle cycles.
module usb_len_hdr_rx #(
  parameter int TIMEOUT_CYC = 1_000_000,
  parameter int TO_W        = 20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        rx_tvalid,
  input  logic [7:0]  rx_tdata,
  output logic [31:0] len,
  output logic        len_valid
);

  logic [1:0]      byte_cnt;
  logic [23:0]     len_lo;
  logic [TO_W-1:0] to_cnt;
  logic            hs;

  assign hs = en & rx_tvalid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byte_cnt <= 2'd0;
      len_lo   <= 24'd0;
      to_cnt   <= '0;
    end else if (hs) begin
      case (byte_cnt)
        2'd0:    len_lo[7:0]   <= rx_tdata;
        2'd1:    len_lo[15:8]  <= rx_tdata;
        2'd2:    len_lo[23:16] <= rx_tdata;
        default: len_lo        <= len_lo;
      endcase
      // Wraps to zero after the 4th byte, so a complete header leaves nothing held.
      byte_cnt <= byte_cnt + 2'd1;
      to_cnt   <= '0;
    end else if (byte_cnt != 2'd0) begin
      if (to_cnt == TO_W'(TIMEOUT_CYC - 1)) begin
        byte_cnt <= 2'd0;
        to_cnt   <= '0;
      end else begin
        to_cnt <= to_cnt + 1'b1;
      end
    end
  end

  assign len       = {rx_tdata, len_lo};
  assign len_valid = hs && (byte_cnt == 2'd3);

endmodule

// File: rtl/usb_len_cmd_streamer.sv
// Turns 4-byte RX length commands into an incrementing-byte TX burst; first word one cycle after the header.
// RX is held off for the whole burst; TX words hold stable under tready backpressure, one word per cycle otherwise.
module usb_len_cmd_streamer
  import usb_stream_pkg::*;
#(
  parameter logic [31:0] MAX_LEN     = 32'h0100_0000,
  parameter int          TIMEOUT_CYC = 1_000_000,
  parameter int          TO_W        = 20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_tvalid,
  input  logic [7:0]  rx_tdata,
  output logic        rx_tready,
  input  logic        tx_tready,
  output logic        tx_tvalid,
  output logic [31:0] tx_tdata,
  output logic [3:0]  tx_tkeep,
  output logic        tx_tlast,
  output logic        busy,
  output logic        len_clamped
);

  state_e      state, state_nxt;
  logic [31:0] tot_len, tot_nxt;
  logic [31:0] sent, sent_nxt;
  logic        clamp_q, clamp_nxt;
  logic [31:0] hdr_len;
  logic        hdr_vld;
  logic [31:0] remaining;
  logic [3:0]  word_keep;
  logic        word_last;

  // Held low during reset so nothing is accepted before the FSM is live.
  assign rx_tready = (state == HDR) & ~rst;

  usb_len_hdr_rx #(
    .TIMEOUT_CYC(TIMEOUT_CYC),
    .TO_W       (TO_W)
  ) u_hdr (
    .clk      (clk),
    .rst      (rst),
    .en       (rx_tready),
    .rx_tvalid(rx_tvalid),
    .rx_tdata (rx_tdata),
    .len      (hdr_len),
    .len_valid(hdr_vld)
  );

  assign remaining = tot_len - sent;
  assign word_keep = tkeep_for(remaining);
  assign word_last = (remaining <= 32'(BYTES_PER_WORD));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= HDR;
      tot_len <= 32'd0;
      sent    <= 32'd0;
      clamp_q <= 1'b0;
    end else begin
      state   <= state_nxt;
      tot_len <= tot_nxt;
      sent    <= sent_nxt;
      clamp_q <= clamp_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    tot_nxt   = tot_len;
    sent_nxt  = sent;
    clamp_nxt = 1'b0;
    case (state)
      HDR: begin
        // A zero-length command is consumed silently.
        if (hdr_vld && (hdr_len != 32'd0)) begin
          state_nxt = SEND;
          sent_nxt  = 32'd0;
          if (hdr_len > MAX_LEN) begin
            tot_nxt   = MAX_LEN;
            clamp_nxt = 1'b1;
          end else begin
            tot_nxt = hdr_len;
          end
        end
      end
      SEND: begin
        if (tx_tready) begin
          if (word_last) begin
            state_nxt = HDR;
            sent_nxt  = 32'd0;
          end else begin
            sent_nxt = sent + 32'(BYTES_PER_WORD);
          end
        end
      end
      default: state_nxt = HDR;
    endcase
  end

  always_comb begin
    tx_tdata = 32'd0;
    if (state == SEND) begin
      for (int i = 0; i < BYTES_PER_WORD; i++) begin
        if (word_keep[i]) tx_tdata[8*i +: 8] = sent[7:0] + 8'(i);
      end
    end
  end

  assign tx_tvalid   = (state == SEND);
  assign tx_tkeep    = (state == SEND) ? word_keep : 4'h0;
  assign tx_tlast    = (state == SEND) & word_last;
  assign busy        = (state == SEND);
  assign len_clamped = clamp_q;

endmodule

// File: tb/tb_usb_len_cmd_streamer.sv
// Directed bench for usb_len_cmd_streamer with MAX_LEN=16 and TIMEOUT_CYC=100.
module tb_usb_len_cmd_streamer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx_tvalid = 1'b0;
  logic [7:0]  rx_tdata = 8'h00;
  logic        rx_tready;
  logic        tx_tready = 1'b0;
  logic        tx_tvalid;
  logic [31:0] tx_tdata;
  logic [3:0]  tx_tkeep;
  logic        tx_tlast;
  logic        busy;
  logic        len_clamped;

  int n_chk  = 0;
  int n_fail = 0;

  usb_len_cmd_streamer #(
    .MAX_LEN    (32'd16),
    .TIMEOUT_CYC(100),
    .TO_W       (20)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_tvalid  (rx_tvalid),
    .rx_tdata   (rx_tdata),
    .rx_tready  (rx_tready),
    .tx_tready  (tx_tready),
    .tx_tvalid  (tx_tvalid),
    .tx_tdata   (tx_tdata),
    .tx_tkeep   (tx_tkeep),
    .tx_tlast   (tx_tlast),
    .busy       (busy),
    .len_clamped(len_clamped)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] req_len;
    int          pat;
    int          exp_words;
    logic        exp_clamp;
    logic [31:0] last_data;
    logic [3:0]  last_keep;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic tready_pat(input int pat, input int cyc);
    logic [5:0] p;
    p = 6'b101001;
    if (pat == 0) return 1'b1;
    return p[cyc % 6];
  endfunction

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_tvalid = 1'b1;
    rx_tdata  = b;
    #1;
    chk("rx_tready_hdr", {31'd0, rx_tready}, 32'd1);
  endtask

  task automatic send_hdr(input logic [31:0] l);
    for (int i = 0; i < 4; i++) send_byte(l[8*i +: 8]);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      rx_tvalid = 1'b0;
    end
  endtask

  task automatic collect(input logic [31:0] eff_len, input int pat, input int exp_words,
                         input logic exp_clamp, input logic [31:0] last_data,
                         input logic [3:0] last_keep);
    int          nw = 0;
    bit          done = 0;
    bit          stalled = 0;
    logic [31:0] hd = 0, rem, md, ld = 0;
    logic [3:0]  hk = 0, mk, lk = 0;
    logic        hl = 0;
    for (int cyc = 0; cyc < 200 && !done; cyc++) begin
      @(negedge clk);
      rx_tvalid = 1'b0;
      tx_tready = tready_pat(pat, cyc);
      #1;
      if (cyc == 0) begin
        chk("first_word_vld", {31'd0, tx_tvalid}, 32'd1);
        chk("clamp_pulse", {31'd0, len_clamped}, {31'd0, exp_clamp});
        chk("busy_send", {31'd0, busy}, 32'd1);
        chk("rx_rdy_send", {31'd0, rx_tready}, 32'd0);
      end
      if (cyc == 1) chk("clamp_one_cycle", {31'd0, len_clamped}, 32'd0);
      if (stalled) begin
        chk("hold_vld", {31'd0, tx_tvalid}, 32'd1);
        chk("hold_dat", tx_tdata, hd);
        chk("hold_keep", {28'd0, tx_tkeep}, {28'd0, hk});
        chk("hold_last", {31'd0, tx_tlast}, {31'd0, hl});
      end
      if (tx_tvalid && tx_tready) begin
        rem = eff_len - 32'(4 * nw);
        if (rem >= 4) mk = 4'hF;
        else if (rem == 3) mk = 4'h7;
        else if (rem == 2) mk = 4'h3;
        else mk = 4'h1;
        md = 32'd0;
        for (int i = 0; i < 4; i++)
          if (mk[i]) md[8*i +: 8] = 8'(4 * nw + i);
        chk("word_dat", tx_tdata, md);
        chk("word_keep", {28'd0, tx_tkeep}, {28'd0, mk});
        chk("word_last", {31'd0, tx_tlast}, {31'd0, (rem <= 4)});
        nw++;
        if (tx_tlast) begin
          done = 1;
          ld   = tx_tdata;
          lk   = tx_tkeep;
        end
      end
      stalled = tx_tvalid && !tx_tready;
      hd = tx_tdata;
      hk = tx_tkeep;
      hl = tx_tlast;
    end
    chk("burst_done", {31'd0, done}, 32'd1);
    chk("word_count", 32'(nw), 32'(exp_words));
    chk("last_word_dat", ld, last_data);
    chk("last_word_keep", {28'd0, lk}, {28'd0, last_keep});
    @(negedge clk);
    tx_tready = 1'b0;
    #1;
    chk("rx_rdy_after", {31'd0, rx_tready}, 32'd1);
    chk("vld_after", {31'd0, tx_tvalid}, 32'd0);
    chk("busy_after", {31'd0, busy}, 32'd0);
  endtask

  task automatic chk_all_zero(input string tag, input logic exp_rdy);
    chk({tag, "_tvalid"}, {31'd0, tx_tvalid}, 32'd0);
    chk({tag, "_tdata"}, tx_tdata, 32'd0);
    chk({tag, "_tkeep"}, {28'd0, tx_tkeep}, 32'd0);
    chk({tag, "_tlast"}, {31'd0, tx_tlast}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_clamp"}, {31'd0, len_clamped}, 32'd0);
    chk({tag, "_rx_rdy"}, {31'd0, rx_tready}, {31'd0, exp_rdy});
  endtask

  initial begin
    int          vcnt;
    logic [31:0] eff;

    vecs[0] = '{32'd5,         0, 2, 1'b0, 32'h0000_0004, 4'h1};
    vecs[1] = '{32'd10,        1, 3, 1'b0, 32'h0000_0908, 4'h3};
    vecs[2] = '{32'h0000_0100, 0, 4, 1'b1, 32'h0F0E_0D0C, 4'hF};
    vecs[3] = '{32'd16,        1, 4, 1'b0, 32'h0F0E_0D0C, 4'hF};
    vecs[4] = '{32'd17,        0, 4, 1'b1, 32'h0F0E_0D0C, 4'hF};
    vecs[5] = '{32'd1,         1, 1, 1'b0, 32'h0000_0000, 4'h1};
    vecs[6] = '{32'd7,         1, 2, 1'b0, 32'h0006_0504, 4'h7};

    #1;
    chk_all_zero("reset", 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk_all_zero("post_reset", 1'b1);

    for (int v = 0; v < 7; v++) begin
      eff = (vecs[v].req_len > 32'd16) ? 32'd16 : vecs[v].req_len;
      send_hdr(vecs[v].req_len);
      collect(eff, vecs[v].pat, vecs[v].exp_words, vecs[v].exp_clamp,
              vecs[v].last_data, vecs[v].last_keep);
    end

    // Zero-length command: nothing sent, next header works normally.
    send_hdr(32'd0);
    vcnt = 0;
    tx_tready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      rx_tvalid = 1'b0;
      #1;
      if (tx_tvalid || busy || !rx_tready) vcnt++;
    end
    tx_tready = 1'b0;
    chk("zero_len_quiet_cycles", 32'(vcnt), 32'd0);
    send_hdr(32'd4);
    collect(32'd4, 0, 1, 1'b0, 32'h0302_0100, 4'hF);

    // 99 idle cycles: partial header survives, giving 0x00030907 -> clamped.
    send_byte(8'h07);
    send_byte(8'h09);
    idle(99);
    send_byte(8'h03);
    send_byte(8'h00);
    collect(32'd16, 0, 4, 1'b1, 32'h0F0E_0D0C, 4'hF);

    // 100 idle cycles: partial header discarded.
    send_byte(8'h07);
    send_byte(8'h09);
    idle(100);
    send_hdr(32'd3);
    collect(32'd3, 0, 1, 1'b0, 32'h0002_0100, 4'h7);

    // Reset in the middle of a burst.
    send_hdr(32'd40);
    @(negedge clk);
    rx_tvalid = 1'b0;
    tx_tready = 1'b1;
    #1;
    chk("pre_rst_w0", tx_tdata, 32'h0302_0100);
    @(negedge clk);
    #1;
    chk("pre_rst_w1", tx_tdata, 32'h0706_0504);
    @(negedge clk);
    #1;
    chk("pre_rst_w2_vld", {31'd0, tx_tvalid}, 32'd1);
    rst = 1'b1;
    #1;
    chk_all_zero("mid_rst", 1'b0);
    tx_tready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk_all_zero("rst_release", 1'b1);
    send_hdr(32'd4);
    collect(32'd4, 0, 1, 1'b0, 32'h0302_0100, 4'hF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
